// File: rtl/lml_reservation_station.sv
// lml_reservation_station: collapsing-queue reservation station for the
// load/move/logic unit. Captures CDB results by tag, issues oldest-ready first.
// Optional macro LML_RS_CDB_WAKEUP_EN: an entry whose last missing operand is on
// the CDB this cycle may issue in the same cycle, taking that operand from cdb_value.
module lml_reservation_station #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [2:0]                   disp_op,
  input  logic [TAG_W-1:0]             disp_tag,
  input  logic                         disp_src1_rdy,
  input  logic [TAG_W-1:0]             disp_src1_tag,
  input  logic [DATA_W-1:0]            disp_src1_val,
  input  logic                         disp_src2_rdy,
  input  logic [TAG_W-1:0]             disp_src2_tag,
  input  logic [DATA_W-1:0]            disp_src2_val,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [DATA_W-1:0]            cdb_value,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output logic [2:0]                   iss_control,
  output logic [DATA_W-1:0]            iss_value1,
  output logic [DATA_W-1:0]            iss_value2,
  output logic [TAG_W-1:0]             iss_tag,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [2:0]        op;
    logic [TAG_W-1:0]  tag;
    logic              s1_rdy;
    logic [TAG_W-1:0]  s1_tag;
    logic [DATA_W-1:0] s1_val;
    logic              s2_rdy;
    logic [TAG_W-1:0]  s2_tag;
    logic [DATA_W-1:0] s2_val;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           cap   [DEPTH+1];
  entry_t           disp_ent;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] wr_idx;
  logic [DEPTH-1:0] elig;
  logic             found;
  logic [IDX_W-1:0] sel_idx;
  logic             iss_fire;
  logic             disp_fire;

  // Apply a CDB broadcast to any waiting source of a valid entry.
  function automatic entry_t capture(input entry_t e, input logic cv,
                                     input logic [TAG_W-1:0] ct,
                                     input logic [DATA_W-1:0] cval);
    entry_t r;
    r = e;
    if (e.valid && cv && !e.s1_rdy && (e.s1_tag == ct)) begin
      r.s1_rdy = 1'b1;
      r.s1_val = cval;
    end
    if (e.valid && cv && !e.s2_rdy && (e.s2_tag == ct)) begin
      r.s2_rdy = 1'b1;
      r.s2_val = cval;
    end
    return r;
  endfunction

  assign occupancy  = cnt_q;
  assign disp_ready = (cnt_q != CNT_W'(DEPTH));
  assign iss_fire   = found & iss_ready & ~flush;
  assign disp_fire  = disp_valid & disp_ready & ~flush;

  // Oldest-first selection among fully ready entries.
  always_comb begin
    elig    = '0;
    found   = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef LML_RS_CDB_WAKEUP_EN
      elig[i] = ent_q[i].valid
              & (ent_q[i].s1_rdy | (cdb_valid & (cdb_tag == ent_q[i].s1_tag)))
              & (ent_q[i].s2_rdy | (cdb_valid & (cdb_tag == ent_q[i].s2_tag)));
`else
      elig[i] = ent_q[i].valid & ent_q[i].s1_rdy & ent_q[i].s2_rdy;
`endif
      if (elig[i] && !found) begin
        found   = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  // Issue port driven from the selected entry, zero when nothing is eligible.
  always_comb begin
    iss_valid   = found;
    iss_control = '0;
    iss_tag     = '0;
    iss_value1  = '0;
    iss_value2  = '0;
    if (found) begin
      iss_control = ent_q[sel_idx].op;
      iss_tag     = ent_q[sel_idx].tag;
`ifdef LML_RS_CDB_WAKEUP_EN
      iss_value1  = ent_q[sel_idx].s1_rdy ? ent_q[sel_idx].s1_val : cdb_value;
      iss_value2  = ent_q[sel_idx].s2_rdy ? ent_q[sel_idx].s2_val : cdb_value;
`else
      iss_value1  = ent_q[sel_idx].s1_val;
      iss_value2  = ent_q[sel_idx].s2_val;
`endif
    end
  end

  // Next queue contents: capture, collapse above the issued slot, append dispatch.
  always_comb begin
    wr_idx = cnt_q - CNT_W'(iss_fire);
    cnt_d  = cnt_q + CNT_W'(disp_fire) - CNT_W'(iss_fire);
    for (int i = 0; i < DEPTH; i++) begin
      cap[i] = capture(ent_q[i], cdb_valid, cdb_tag, cdb_value);
    end
    cap[DEPTH] = '0;

    disp_ent        = '0;
    disp_ent.valid  = 1'b1;
    disp_ent.op     = disp_op;
    disp_ent.tag    = disp_tag;
    disp_ent.s1_rdy = disp_src1_rdy;
    disp_ent.s1_tag = disp_src1_tag;
    disp_ent.s1_val = disp_src1_val;
    disp_ent.s2_rdy = disp_src2_rdy;
    disp_ent.s2_tag = disp_src2_tag;
    disp_ent.s2_val = disp_src2_val;
    disp_ent        = capture(disp_ent, cdb_valid, cdb_tag, cdb_value);

    for (int i = 0; i < DEPTH; i++) begin
      if (iss_fire && (IDX_W'(i) >= sel_idx)) begin
        ent_d[i] = cap[i+1];
      end else begin
        ent_d[i] = cap[i];
      end
      if (disp_fire && (CNT_W'(i) == wr_idx)) begin
        ent_d[i] = disp_ent;
      end
    end
  end

  // Queue and count registers; reset and flush both empty the station.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      cnt_q <= cnt_d;
    end
  end

endmodule
